// File: rtl/branch_predictor_bht_pkg.sv
// Shared definitions for the branch history table: 2-bit counter
// encoding, reset value and the saturating counter update rule.
package branch_predictor_bht_pkg;

    typedef logic [1:0] cnt_t;

    // Counter encoding: bit 1 is the taken prediction.
    localparam cnt_t SNT = 2'b00;
    localparam cnt_t WNT = 2'b01;
    localparam cnt_t WT  = 2'b10;
    localparam cnt_t ST  = 2'b11;

    // Every entry starts weakly not-taken so one taken outcome flips it.
    localparam cnt_t CNT_RST = WNT;

    // Next counter value after one resolution; saturates at both ends.
    function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
        cnt_t nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) begin
                nxt = cnt + 2'd1;
            end
        end else begin
            if (cnt != SNT) begin
                nxt = cnt - 2'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter_array.sv
// Table of 2-bit saturating counters: async reset to CNT_RST, one
// read-modify-write training port and one combinational read port.
// Ports: clk, rst, wr_en/wr_idx/wr_taken (training), rd_idx/rd_cnt (lookup).
module bht_sat_counter_array
    import branch_predictor_bht_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic               wr_taken,
    input  logic [INDEX_W-1:0] rd_idx,
    output cnt_t               rd_cnt
);

    localparam int DEPTH = 2 ** INDEX_W;

    cnt_t cnt_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_mem[i] <= CNT_RST;
            end
        end else if (wr_en) begin
            cnt_mem[wr_idx] <= sat_update(cnt_mem[wr_idx], wr_taken);
        end
    end

    // No write-to-read bypass: a lookup in the training cycle sees the old value.
    assign rd_cnt = cnt_mem[rd_idx];

endmodule

// File: rtl/branch_predictor_bht.sv
// Fetch-side bimodal branch predictor with mispredict flag and statistics.
// Ports: clk, rst; fetch_valid/fetch_pc -> pred_taken (combinational);
// res_valid/res_pc/res_taken/res_pred train the table; mispredict is a
// registered pulse; branch_cnt/mispred_cnt are saturating event counters.
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic             res_taken,
    input  logic             res_pred,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic [INDEX_W-1:0] fetch_idx;
    logic [INDEX_W-1:0] res_idx;
    cnt_t               fetch_cnt;
    logic               res_miss;
    logic               mispredict_q;
    logic [CNT_W-1:0]   branch_q;
    logic [CNT_W-1:0]   mispred_q;

    // Word-aligned, untagged index; upper PC bits alias freely.
    assign fetch_idx = fetch_pc[INDEX_W+1:2];
    assign res_idx   = res_pc[INDEX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[31:INDEX_W+2], fetch_pc[1:0],
                              res_pc[31:INDEX_W+2], res_pc[1:0]};

    bht_sat_counter_array #(
        .INDEX_W (INDEX_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (res_valid),
        .wr_idx   (res_idx),
        .wr_taken (res_taken),
        .rd_idx   (fetch_idx),
        .rd_cnt   (fetch_cnt)
    );

    assign pred_taken = fetch_valid & fetch_cnt[1];

    assign res_miss = res_valid & (res_taken ^ res_pred);

    // Reloaded every edge, so an idle cycle clears it and a run of
    // mispredicts keeps it high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_q <= 1'b0;
        end else begin
            mispredict_q <= res_miss;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_q  <= '0;
            mispred_q <= '0;
        end else begin
            if (res_valid && (branch_q != '1)) begin
                branch_q <= branch_q + CNT_W'(1);
            end
            if (res_miss && (mispred_q != '1)) begin
                mispred_q <= mispred_q + CNT_W'(1);
            end
        end
    end

    assign mispredict  = mispredict_q;
    assign branch_cnt  = branch_q;
    assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed self-checking bench for branch_predictor_bht.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_branch_predictor_bht;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic        res_pred;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int vectors;
    int miscompares;

    branch_predictor_bht #(
        .INDEX_W (6),
        .CNT_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .pred_taken  (pred_taken),
        .res_valid   (res_valid),
        .res_pc      (res_pc),
        .res_taken   (res_taken),
        .res_pred    (res_pred),
        .mispredict  (mispredict),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic v, input logic [31:0] pc,
                           input logic t, input logic p);
        res_valid = v;
        res_pc    = pc;
        res_taken = t;
        res_pred  = p;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch_valid = 1'b1;
        fetch_pc = 32'h40;
        set_res(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pred got %b want 0", pred_taken);
        end
        vectors++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cnts got %0d/%0d want 0/0", branch_cnt, mispred_cnt);
        end
        vectors++;
        if (mispredict !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mispredict got %b want 0", mispredict);
        end
    endtask

    // Entry 16: 01 -> 10 -> 11 -> 11.
    task automatic test_train_taken();
        fetch_pc = 32'h40;
        set_res(1'b1, 32'h40, 1'b1, 1'b0);
        tick();
        vectors++;
        if (pred_taken !== 1'b1 || mispredict !== 1'b1 || branch_cnt !== 32'd1
            || mispred_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL taken_1 got p=%b m=%b b=%0d mc=%0d want 1 1 1 1",
                     pred_taken, mispredict, branch_cnt, mispred_cnt);
        end
        tick();
        vectors++;
        if (pred_taken !== 1'b1 || mispredict !== 1'b1 || branch_cnt !== 32'd2
            || mispred_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL taken_2 got p=%b m=%b b=%0d mc=%0d want 1 1 2 2",
                     pred_taken, mispredict, branch_cnt, mispred_cnt);
        end
        set_res(1'b0, 32'h40, 1'b1, 1'b0);
        tick();
        vectors++;
        if (mispredict !== 1'b0) begin
            miscompares++;
            $display("FAIL mispredict_clear got %b want 0", mispredict);
        end
        set_res(1'b1, 32'h40, 1'b1, 1'b1);
        tick();
        tick();
        set_res(1'b0, 32'h40, 1'b0, 1'b0);
        vectors++;
        if (pred_taken !== 1'b1 || mispredict !== 1'b0 || branch_cnt !== 32'd4
            || mispred_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL taken_sat got p=%b m=%b b=%0d mc=%0d want 1 0 4 2",
                     pred_taken, mispredict, branch_cnt, mispred_cnt);
        end
    endtask

    // Entry 16: 11 -> 10 -> 01 -> 00 -> 00, then 01, 10 to prove the floor.
    task automatic test_sat_not_taken();
        logic [3:0] want_p;
        want_p = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            set_res(1'b1, 32'h40, 1'b0, (i < 2) ? 1'b1 : 1'b0);
            tick();
            vectors++;
            if (pred_taken !== want_p[3-i]) begin
                miscompares++;
                $display("FAIL nt_step%0d got %b want %b", i, pred_taken, want_p[3-i]);
            end
        end
        vectors++;
        if (branch_cnt !== 32'd8 || mispred_cnt !== 32'd4 || mispredict !== 1'b0) begin
            miscompares++;
            $display("FAIL nt_cnts got b=%0d mc=%0d m=%b want 8 4 0",
                     branch_cnt, mispred_cnt, mispredict);
        end
        set_res(1'b1, 32'h40, 1'b1, 1'b0);
        tick();
        vectors++;
        if (pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL nt_floor got %b want 0", pred_taken);
        end
        tick();
        set_res(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (pred_taken !== 1'b1 || mispred_cnt !== 32'd6) begin
            miscompares++;
            $display("FAIL nt_recover got p=%b mc=%0d want 1 6", pred_taken, mispred_cnt);
        end
    endtask

    // Entry 16 is 10 here; 0x140 and 0x43 alias to it, 0x44 does not.
    task automatic test_alias();
        fetch_pc = 32'h140;
        #1;
        vectors++;
        if (pred_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL alias_read got %b want 1", pred_taken);
        end
        fetch_pc = 32'h44;
        #1;
        vectors++;
        if (pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL other_index got %b want 0", pred_taken);
        end
        fetch_pc = 32'h40;
        fetch_valid = 1'b0;
        #1;
        vectors++;
        if (pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_invalid got %b want 0", pred_taken);
        end
        fetch_valid = 1'b1;
        set_res(1'b1, 32'h140, 1'b0, 1'b1);
        tick();
        set_res(1'b0, 32'h0, 1'b0, 1'b0);
        fetch_pc = 32'h43;
        #1;
        vectors++;
        if (pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL alias_train got %b want 0", pred_taken);
        end
    endtask

    // Entry 16 is 01; read and train it in the same cycle.
    task automatic test_same_cycle();
        fetch_pc = 32'h40;
        set_res(1'b1, 32'h40, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_old got %b want 0", pred_taken);
        end
        @(posedge clk);
        #1;
        set_res(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (pred_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_new got %b want 1", pred_taken);
        end
    endtask

    task automatic test_back_to_back();
        set_res(1'b1, 32'h48, 1'b1, 1'b0);
        tick();
        set_res(1'b1, 32'h40, 1'b1, 1'b1);
        tick();
        vectors++;
        if (mispredict !== 1'b0 || branch_cnt !== 32'd14 || mispred_cnt !== 32'd9) begin
            miscompares++;
            $display("FAIL b2b got m=%b b=%0d mc=%0d want 0 14 9",
                     mispredict, branch_cnt, mispred_cnt);
        end
        set_res(1'b0, 32'h0, 1'b0, 1'b0);
        fetch_pc = 32'h48;
        #1;
        vectors++;
        if (pred_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_entry18 got %b want 1", pred_taken);
        end
        fetch_pc = 32'h4C;
        #1;
        vectors++;
        if (pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_entry19 got %b want 0", pred_taken);
        end
    endtask

    // Entry 16 is 11, entry 18 is 10; reset lands between edges.
    task automatic test_reset_mid();
        fetch_pc = 32'h40;
        @(negedge clk);
        set_res(1'b1, 32'h40, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if (pred_taken !== 1'b0 || mispredict !== 1'b0 || branch_cnt !== 32'd0
            || mispred_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_async got p=%b m=%b b=%0d mc=%0d want 0 0 0 0",
                     pred_taken, mispredict, branch_cnt, mispred_cnt);
        end
        tick();
        @(negedge clk);
        set_res(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        vectors++;
        if (pred_taken !== 1'b0 || branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_res_discard got p=%b b=%0d mc=%0d want 0 0 0",
                     pred_taken, branch_cnt, mispred_cnt);
        end
        set_res(1'b1, 32'h48, 1'b1, 1'b0);
        fetch_pc = 32'h48;
        tick();
        set_res(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (pred_taken !== 1'b1 || branch_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL reset_wnt got p=%b b=%0d want 1 1", pred_taken, branch_cnt);
        end
    endtask

    task automatic test_stat_sat();
        @(negedge clk);
        force dut.branch_q = 32'hFFFF_FFFE;
        force dut.mispred_q = 32'hFFFF_FFFF;
        #1;
        release dut.branch_q;
        release dut.mispred_q;
        set_res(1'b1, 32'h80, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (branch_cnt !== 32'hFFFF_FFFF || mispred_cnt !== 32'hFFFF_FFFF) begin
                miscompares++;
                $display("FAIL stat_sat%0d got %h/%h want ffffffff/ffffffff",
                         i, branch_cnt, mispred_cnt);
            end
        end
        set_res(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_train_taken();
        test_sat_not_taken();
        test_alias();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_stat_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
